// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types and constants for the shared add/sub arbiter.
//   state_e  : controller states (StIdle, StExec, StResp)
//   FLAG_*   : bit positions of N/Z/C/V inside the 4-bit flag vector
//   req_id_t : requester identifier (two requesters, 1 bit)
//   sat_inc8 : saturating 8-bit increment used by the optional grant counters
package adder_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic req_id_t;

  localparam logic [7:0] CntMax = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == CntMax) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way round-robin pick.
//   valid [1:0] in  : request lines
//   ptr         in  : preferred requester this round
//   grant [1:0] out : one-hot grant (zero when nothing is valid)
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // The preferred requester wins if valid; otherwise the other one may take it.
  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] & (~ptr | ~valid[1]);
    grant[1] = valid[1] & (ptr | ~valid[0]);
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: one WIDTH-bit add/subtract unit with N/Z/C/V flags shared
// between two requesters under round-robin arbitration.
//
// Flow: IDLE grants and captures operands, EXEC computes and registers the result,
// RESP presents it until rsp_ready. Accept at T gives rsp_valid at T+2.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid[1:0]          per-requester request valid
//   req_ready[1:0]          per-requester accept (only in IDLE, only granted bit)
//   req_sub[1:0]            per-requester op: 0 = A+B, 1 = A-B
//   req_a0/b0, req_a1/b1    operands for requester 0 / 1
//   rsp_valid, rsp_ready    response handshake
//   rsp_id                  owner of the response
//   rsp_sum                 result
//   rsp_flags               {N,Z,C,V}
//   grant_cnt0/1            saturating transfer counters (only with ADD_ARB_STATS_EN)
//
// Optional feature macro: ADD_ARB_STATS_EN
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_sub,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
`ifdef ADD_ARB_STATS_EN
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1,
`endif
  output logic [3:0]       rsp_flags
);

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  req_id_t          owner_q, owner_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [3:0]       flags_q, flags_d;

  logic [1:0]       grant;
  logic             xfer;

  rr_arbiter_2 u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Ready is gated by reset so nothing looks accepted while reset is held.
  assign req_ready = ((state_q == StIdle) && rst_n) ? grant : 2'b00;
  assign xfer      = |(req_valid & req_ready);

  // Datapath: subtract is a + ~b + 1, so the carry-out means "no borrow".
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] res;
  logic [3:0]       flags_calc;

  always_comb begin
    b_eff = sub_q ? ~b_q : b_q;
    full  = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_q};
    res   = full[WIDTH-1:0];

    flags_calc         = 4'b0000;
    flags_calc[FLAG_N] = res[WIDTH-1];
    flags_calc[FLAG_Z] = (res == '0);
    flags_calc[FLAG_C] = full[WIDTH];
    // Overflow when both adder inputs share a sign that the result does not.
    flags_calc[FLAG_V] = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    owner_d  = owner_q;
    sum_d    = sum_q;
    flags_d  = flags_q;

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          owner_d = grant[1];
          a_d     = grant[1] ? req_a1 : req_a0;
          b_d     = grant[1] ? req_b1 : req_b0;
          sub_d   = grant[1] ? req_sub[1] : req_sub[0];
          state_d = StExec;
        end
      end
      StExec: begin
        sum_d   = res;
        flags_d = flags_calc;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rr_ptr_d = ~owner_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      owner_q  <= 1'b0;
      sum_q    <= '0;
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      owner_q  <= owner_d;
      sum_q    <= sum_d;
      flags_q  <= flags_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = owner_q;
  assign rsp_sum   = sum_q;
  assign rsp_flags = flags_q;

`ifdef ADD_ARB_STATS_EN
  logic [7:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else if (xfer) begin
      if (grant[0]) cnt0_q <= sat_inc8(cnt0_q);
      if (grant[1]) cnt1_q <= sat_inc8(cnt1_q);
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed scenarios plus randomized
// traffic against a behavioural model that computes results with integer arithmetic.
module tb_adder_share_arbiter;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_sub;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic [3:0]   rsp_flags;
`ifdef ADD_ARB_STATS_EN
  logic [7:0]   grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sub   (req_sub),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
`ifdef ADD_ARB_STATS_EN
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1),
`endif
    .rsp_flags (rsp_flags)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase 0 = free, 1 = computing, 2 = response pending.
  int           ph;
  int           ptr;
  int           own;
  int           cnt0, cnt1;
  logic [W-1:0] exp_sum;
  logic [3:0]   exp_flags;

  logic [1:0]   obs_ready;
  int           id_log[$];
  int           sum_log[$];
  int           flags_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result from unsigned/signed integer arithmetic.
  task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] s, output logic [3:0] f);
    int ua, ub, sa, sb, ur, sr;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= M / 2) ? ua - M : ua;
    sb = (ub >= M / 2) ? ub - M : ub;
    ur = sub ? ua - ub : ua + ub;
    s  = W'(((ur % M) + M) % M);
    c  = sub ? (ua >= ub) : (ur >= M);
    sr = sub ? sa - sb : sa + sb;
    v  = (sr > M / 2 - 1) || (sr < -(M / 2));
    f  = {s[W-1], (s == '0), c, v};
  endtask

  function automatic logic [1:0] pick(input logic [1:0] v, input int p);
    if (v[p]) return (p == 0) ? 2'b01 : 2'b10;
    if (v[1-p]) return (p == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  // One clock cycle: drive, check at negedge, advance the model, return at posedge+1.
  task automatic step(input logic [1:0] v, input logic [1:0] s,
                      input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [W-1:0] a1, input logic [W-1:0] b1, input logic rr);
    logic [1:0] g;
    req_valid = v;
    req_sub   = s;
    req_a0    = a0;
    req_b0    = b0;
    req_a1    = a1;
    req_b1    = b1;
    rsp_ready = rr;
    @(negedge clk);
    g = (ph == 0) ? pick(v, ptr) : 2'b00;
    obs_ready = req_ready;
    check("req_ready", req_ready, g);
    check("rsp_valid", rsp_valid, (ph == 2));
    if (ph == 2) begin
      check("rsp_id", rsp_id, own);
      check("rsp_sum", rsp_sum, exp_sum);
      check("rsp_flags", rsp_flags, exp_flags);
      if (rr) begin
        id_log.push_back(int'(rsp_id));
        sum_log.push_back(int'(rsp_sum));
        flags_log.push_back(int'(rsp_flags));
      end
    end
`ifdef ADD_ARB_STATS_EN
    check("grant_cnt0", grant_cnt0, cnt0);
    check("grant_cnt1", grant_cnt1, cnt1);
`endif
    if (ph == 0) begin
      if (g != 2'b00) begin
        own = g[1] ? 1 : 0;
        if (own == 1) begin
          ref_op(a1, b1, s[1], exp_sum, exp_flags);
          if (cnt1 < 255) cnt1++;
        end else begin
          ref_op(a0, b0, s[0], exp_sum, exp_flags);
          if (cnt0 < 255) cnt0++;
        end
        ph = 1;
      end
    end else if (ph == 1) begin
      ph = 2;
    end else if (rr) begin
      ptr = 1 - own;
      ph  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ph   = 0;
    ptr  = 0;
    own  = 0;
    cnt0 = 0;
    cnt1 = 0;
  endtask

  task automatic do_reset();
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #2;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_sum", rsp_sum, '0);
    check("rst_rsp_flags", rsp_flags, 4'b0000);
`ifdef ADD_ARB_STATS_EN
    check("rst_cnt0", grant_cnt0, 8'd0);
    check("rst_cnt1", grant_cnt1, 8'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = 2'b00;
    req_sub   = 2'b00;
    req_a0    = '0;
    req_b0    = '0;
    req_a1    = '0;
    req_b1    = '0;
    rsp_ready = 1'b0;
    model_reset();
    #1;
    do_reset();

    // Requester 0 alone: 2 + 13.
    step(2'b01, 2'b00, 4'd2, 4'd13, 4'd0, 4'd0, 1'b1);
    step(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("t1_id", id_log[$], 0);
    check("t1_sum", sum_log[$], 15);
    check("t1_flags", flags_log[$], 4'b1000);

    // Requester 1 alone: 8 + 13, then 5 - 5.
    step(2'b10, 2'b00, 4'd0, 4'd0, 4'd8, 4'd13, 1'b1);
    step(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("t2a_sum", sum_log[$], 5);
    check("t2a_flags", flags_log[$], 4'b0011);
    step(2'b10, 2'b10, 4'd0, 4'd0, 4'd5, 4'd5, 1'b1);
    step(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("t2b_sum", sum_log[$], 0);
    check("t2b_flags", flags_log[$], 4'b0110);

    // Both held valid after reset: service alternates starting with requester 0.
    do_reset();
    id_log.delete();
    sum_log.delete();
    flags_log.delete();
    for (int i = 0; i < 12; i++) step(2'b11, 2'b00, 4'd0, 4'd15, 4'd10, 4'd1, 1'b1);
    check("t3_count", id_log.size(), 4);
    if (id_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("t3_order", id_log[i], i % 2);
      check("t3_sum0", sum_log[0], 15);
      check("t3_flags0", flags_log[0], 4'b1000);
      check("t3_sum1", sum_log[1], 11);
      check("t3_flags1", flags_log[1], 4'b1000);
    end

    // Backpressure: response held five cycles while both requesters wait.
    step(2'b01, 2'b01, 4'd3, 4'd9, 4'd0, 4'd0, 1'b0);
    step(2'b11, 2'b00, 4'd7, 4'd7, 4'd7, 4'd7, 1'b0);
    for (int i = 0; i < 5; i++)
      step(2'b11, 2'b11, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0);
    step(2'b11, 2'b00, 4'd1, 4'd1, 4'd1, 4'd1, 1'b1);
    step(2'b11, 2'b00, 4'd1, 4'd1, 4'd1, 4'd1, 1'b1);
    check("t4_next_grant", obs_ready, 2'b10);

    // Reset during EXEC discards the transaction and returns the pointer to 0.
    step(2'b01, 2'b00, 4'd1, 4'd1, 4'd0, 4'd0, 1'b1);
    step(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step(2'b01, 2'b00, 4'd3, 4'd4, 4'd0, 4'd0, 1'b1);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("t5_rsp_valid", rsp_valid, 1'b0);
    check("t5_req_ready", req_ready, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 4'd3, 4'd4, 4'd3, 4'd4, 1'b1);
    step(2'b11, 2'b00, 4'd3, 4'd4, 4'd3, 4'd4, 1'b1);
    check("t5_ptr", obs_ready, 2'b01);
    step(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);

    // Randomized traffic, including dropped valids and stalled responses.
    for (int i = 0; i < 1500; i++) begin
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           W'($urandom), W'($urandom), W'($urandom), W'($urandom),
           ($urandom_range(0, 3) != 0));
    end

`ifdef ADD_ARB_STATS_EN
    // Counter saturation with back-to-back requester 0 traffic.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(2'b01, 2'b00, W'($urandom), W'($urandom), 4'd0, 4'd0, 1'b1);
      step(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
      step(2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    end
    check("t6_cnt0", grant_cnt0, 8'd255);
    check("t6_cnt1", grant_cnt1, 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
Shares one WIDTH-bit add/subtract datapath with N/Z/C/V flags between two requesters.
- Round-robin arbitration; operands registered, then computed, then returned on one response channel tagged with requester ID.
- Sits between the lab ALU datapath and two client FSMs (e.g. an address incrementer and an accumulator) that previously each needed a private adder.

Parameters:
WIDTH, 4, operand/result width in bits (minimum 2)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request valid (bit i = requester i)
req_ready  out  2  per-requester accept strobe; transfer when valid&ready on the same bit
req_sub  in  2  per-requester op select: 0 = A+B, 1 = A-B
req_a0  in  WIDTH  operand A, requester 0
req_b0  in  WIDTH  operand B, requester 0
req_a1  in  WIDTH  operand A, requester 1
req_b1  in  WIDTH  operand B, requester 1
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  requester that owns the result
rsp_sum  out  WIDTH  result
rsp_flags  out  4  {N,Z,C,V}

Behaviour:
- Reset is asynchronous and clears immediately: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_flags=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = requester rr_ptr if its valid is set, else the other requester if its valid is set, else none.
  - req_ready[grant] is combinational: high only in IDLE, and only for the granted bit. Both ready bits are never high together.
  - On transfer: capture a, b, sub and owner id; go to EXEC.
- EXEC (one cycle):
  - Compute a + (sub ? ~b : b) + sub in WIDTH+1 bits.
  - Register rsp_sum = low WIDTH bits.
  - Flags:
    - N = msb of the result.
    - Z = (result == 0).
    - C = bit WIDTH; for subtract, C=1 means no borrow (a >= b unsigned).
    - V = signed overflow: operand signs equal (after B inversion) and result sign differs.
  - Go to RESP.
- RESP:
  - rsp_valid=1, with id, sum and flags stable.
  - On rsp_ready: go to IDLE and set rr_ptr = ~owner.
  - rsp_ready low holds everything indefinitely.
- Latency: accept at cycle T, rsp_valid high at T+2. Peak throughput is one operation per 3 cycles (response accepted the cycle rsp_valid rises).
- No new request is accepted before the current response is consumed. req_ready is 0 in EXEC and RESP.
- Simultaneous valids: rr_ptr decides; the loser keeps valid high and is served next.
- A requester dropping valid before ready is legal; no transfer occurs.
- Reset mid-operation: the transaction is discarded; no response is ever produced for it.
- Operands are not sampled outside the IDLE transfer cycle.

Optional Feature:
Macro ADD_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (8 bits each, out).
  - Each increments on a request transfer of its requester and saturates at 255.
  - Both clear on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
Shared package adder_arb_pkg holds:
- state enum (IDLE, EXEC, RESP)
- flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- requester ID typedef (1 bit)

Sub-module rr_arbiter_2:
- Combinational 2-way round-robin pick.
- Inputs: valid[1:0], ptr. Outputs: one-hot grant[1:0].
- Instantiated once. The add/sub and flag logic stays inline.

Test Plan:
- Req0 only, a=2, b=13, add, rsp_ready=1 → ready pulses at T, rsp at T+2: id=0, sum=15, NZCV=1000.
- Req1 only, a=8, b=13, add → sum=5, NZCV=0011; then a=5, b=5, sub → sum=0, NZCV=0110.
- Both valid right after reset (req0 a=0 b=15 add; req1 a=10 b=1 add) → req0 served first (sum=15, NZCV=1000), then req1 (sum=11, NZCV=1000); repeat with both held → service alternates 1,0,1.
- Backpressure: rsp_ready low 5 cycles in RESP → rsp_valid, id, sum, flags stable; req_ready stays 00; completes on the cycle rsp_ready rises.
- Reset asserted during EXEC of a=3, b=4 → rsp_valid=0 immediately; after release no response appears; rr_ptr=0.
- With ADD_ARB_STATS_EN: 300 back-to-back req0 transactions → grant_cnt0=255, grant_cnt1=0.
